accel_channel_scheduler: RTL and testbench



---
 rtl/accel_channel_scheduler_pkg.sv | 22 ++
 rtl/accel_channel_scheduler_if.sv | 33 +++
 rtl/accel_channel_scheduler_rr_arbiter.sv | 40 ++++
 rtl/accel_channel_scheduler.sv | 155 +++++++++++++++
 tb/tb_accel_channel_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/accel_channel_scheduler_pkg.sv
// conv_sched_pkg: shared types and width helpers for accel_channel_scheduler.
//   sched_state_t : scheduler FSM state codes (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   CH_IDX_W      : channel index width, never narrower than 1 bit
//   TMO_CNT_W     : width of the WAIT timeout counter (counts 0..TIMEOUT_CYCLES-1)
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  function automatic int CH_IDX_W(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int TMO_CNT_W(input int timeout_cycles);
    return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  endfunction

endpackage

// File: rtl/accel_channel_scheduler_if.sv
// accel_channel_scheduler_if: requester-side handshake bundle of the scheduler.
//   req_valid/req_ready   : per-channel window request handshake (one-hot ready)
//   req_data/req_filter   : flat operands, channel n at [n*KK*DW +: KK*DW]
//   rsp_valid/rsp_ready   : per-channel result handshake (one-hot valid)
//   rsp_data/rsp_timeout  : shared result bus and timed-out-result flag
// Modports: master = requesters (Convolution_Controller side), slave = scheduler.
interface accel_channel_scheduler_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int CHANNELS    = 2
);
  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;

  logic [CHANNELS-1:0]               req_valid;
  logic [CHANNELS-1:0]               req_ready;
  logic [CHANNELS*KK*DATA_WIDTH-1:0] req_data;
  logic [CHANNELS*KK*DATA_WIDTH-1:0] req_filter;
  logic [CHANNELS-1:0]               rsp_valid;
  logic [CHANNELS-1:0]               rsp_ready;
  logic [DATA_WIDTH-1:0]             rsp_data;
  logic                              rsp_timeout;

  modport master (
    output req_valid, req_data, req_filter, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_timeout
  );

  modport slave (
    input  req_valid, req_data, req_filter, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_timeout
  );

endinterface

// File: rtl/accel_channel_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       in  CHANNELS  pending requests
//   rr_ptr    in  IW        highest-priority channel for this pick
//   grant     out CHANNELS  one-hot grant (all zero when nothing requests)
//   grant_idx out IW        index of the granted channel (0 when none)
module rr_arbiter
  import conv_sched_pkg::*;
#(
  parameter int CHANNELS = 2
) (
  input  logic [CHANNELS-1:0]           req,
  input  logic [CH_IDX_W(CHANNELS)-1:0] rr_ptr,
  output logic [CHANNELS-1:0]           grant,
  output logic [CH_IDX_W(CHANNELS)-1:0] grant_idx
);
  localparam int IW = CH_IDX_W(CHANNELS);

  logic found;
  int   pos;

  // Scan channels starting at rr_ptr, wrapping past CHANNELS-1; first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= CHANNELS) pos = pos - CHANNELS;
      for (int j = 0; j < CHANNELS; j++) begin
        if (!found && req[j] && (j == pos)) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/accel_channel_scheduler.sv
// accel_channel_scheduler: time-shares one matrixAccelerator between CHANNELS requesters.
// Round-robin accepts one window/filter pair, drives the accelerator operands, pulses
// accel_start for one cycle, waits for accel_ready and returns accel_sum to the granted channel.
//   Clk, Rst           clock, synchronous active-high reset
//   chan (slave)       request/response handshake bundle
//   accel_multiplier   window operands to the accelerator
//   accel_multiplicand filter operands to the accelerator
//   accel_start        start pulse, all KK bits identical
//   accel_sum/ready    accelerator result and its completion strobe
//   busy               FSM not in IDLE
//   grant_id           index of the current/last granted channel
// Optional build macro: SCHED_TIMEOUT_EN adds a WAIT timeout of TIMEOUT_CYCLES cycles that
// answers with rsp_data=0 and rsp_timeout=1.
module accel_channel_scheduler
  import conv_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int KERNEL_SIZE    = 3,
  parameter int CHANNELS       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                        Clk,
  input  logic                                        Rst,
  accel_channel_scheduler_if.slave                    chan,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] accel_multiplier,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] accel_multiplicand,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]          accel_start,
  input  logic [DATA_WIDTH-1:0]                       accel_sum,
  input  logic                                        accel_ready,
  output logic                                        busy,
  output logic [CH_IDX_W(CHANNELS)-1:0]               grant_id
);
  localparam int KK  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int OPW = KK * DATA_WIDTH;
  localparam int IW  = CH_IDX_W(CHANNELS);

  sched_state_t          state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, grant_id_q, arb_idx;
  logic [CHANNELS-1:0]   arb_grant, req_ready_c, rsp_valid_c, rsp_onehot;
  logic [OPW-1:0]        mult_q, mcand_q, sel_data, sel_filt;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_fire, tmo_expire;

  rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
    .req       (chan.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Operand mux keyed by the one-hot grant so every slice base is a constant.
  always_comb begin
    sel_data = '0;
    sel_filt = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (arb_grant[n]) begin
        sel_data = chan.req_data[n*OPW +: OPW];
        sel_filt = chan.req_filter[n*OPW +: OPW];
      end
    end
  end

  assign rsp_onehot = CHANNELS'(1) << grant_id_q;
  assign rsp_fire   = |(rsp_onehot & chan.rsp_ready);

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // accel_ready is only looked at in WAIT, so strobes in IDLE/ISSUE are dropped as stale.
  always_comb begin
    state_d     = state_q;
    req_ready_c = '0;
    rsp_valid_c = '0;
    accel_start = '0;
    case (state_q)
      IDLE: begin
        req_ready_c = arb_grant;
        if (|arb_grant) state_d = ISSUE;
      end
      ISSUE: begin
        accel_start = '1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (accel_ready || tmo_expire) state_d = RESP;
      end
      RESP: begin
        rsp_valid_c = rsp_onehot;
        if (rsp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands and grant are captured on the accepting cycle and held until the next accept.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      mult_q     <= '0;
      mcand_q    <= '0;
      grant_id_q <= '0;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
    end else begin
      if (state_q == IDLE && |arb_grant) begin
        mult_q     <= sel_data;
        mcand_q    <= sel_filt;
        grant_id_q <= arb_idx;
      end
      if (state_q == WAIT) begin
        if (accel_ready)     rsp_data_q <= accel_sum;
        else if (tmo_expire) rsp_data_q <= '0;
      end
      if (state_q == RESP && rsp_fire)
        rr_ptr_q <= (grant_id_q == IW'(CHANNELS-1)) ? '0 : grant_id_q + 1'b1;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = TMO_CNT_W(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_flag_q;

  // Counter sits at zero outside WAIT, so every WAIT entry starts a fresh count.
  assign tmo_expire = (tmo_cnt_q == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_cnt_q  <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if (state_q == WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      else                 tmo_cnt_q <= '0;
      if (state_q == WAIT)                tmo_flag_q <= !accel_ready && tmo_expire;
      else if (state_q == RESP && rsp_fire) tmo_flag_q <= 1'b0;
    end
  end

  assign chan.rsp_timeout = (state_q == RESP) && tmo_flag_q;
`else
  assign tmo_expire       = 1'b0;
  assign chan.rsp_timeout = 1'b0;
`endif

  assign chan.req_ready     = req_ready_c;
  assign chan.rsp_valid     = rsp_valid_c;
  assign chan.rsp_data      = rsp_data_q;
  assign accel_multiplier   = mult_q;
  assign accel_multiplicand = mcand_q;
  assign busy               = (state_q != IDLE);
  assign grant_id           = grant_id_q;

endmodule

// File: tb/tb_accel_channel_scheduler.sv
// Testbench for accel_channel_scheduler: directed scenarios plus randomized jobs, checked
// against a behavioural round-robin/dot-product model. Define SCHED_TIMEOUT_EN to add the
// timeout scenario (TIMEOUT_CYCLES=8).
module tb_accel_channel_scheduler;
  import conv_sched_pkg::*;

  localparam int DW  = 32;
  localparam int KS  = 3;
  localparam int CH  = 2;
  localparam int KK  = KS * KS;
  localparam int OPW = KK * DW;
  localparam int IW  = CH_IDX_W(CH);
`ifdef SCHED_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic           Clk = 1'b0;
  logic           Rst;
  logic [OPW-1:0] accel_multiplier, accel_multiplicand;
  logic [KK-1:0]  accel_start;
  logic [DW-1:0]  accel_sum;
  logic           accel_ready;
  logic           busy;
  logic [IW-1:0]  grant_id;

  always #5 Clk = ~Clk;

  accel_channel_scheduler_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .CHANNELS(CH)) bus ();

  accel_channel_scheduler #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(KS), .CHANNELS(CH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .chan               (bus),
    .accel_multiplier   (accel_multiplier),
    .accel_multiplicand (accel_multiplicand),
    .accel_start        (accel_start),
    .accel_sum          (accel_sum),
    .accel_ready        (accel_ready),
    .busy               (busy),
    .grant_id           (grant_id)
  );

  logic [DW-1:0] winMem  [CH][KK];
  logic [DW-1:0] filtMem [CH][KK];
  int modelPtr;
  int checkCount;
  int errorCount;
  int granted;

  task automatic checkOutput(input string tag, input logic [OPW-1:0] actual,
                             input logic [OPW-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Reference result: plain dot product of the channel's window and filter, mod 2^DW.
  function automatic logic [DW-1:0] dotProduct(input int ch);
    logic [DW-1:0] s = '0;
    for (int i = 0; i < KK; i++) s += winMem[ch][i] * filtMem[ch][i];
    return s;
  endfunction

  // Model accelerator: multiply-accumulate over whatever operands the DUT presents.
  function automatic logic [DW-1:0] accelModelSum();
    logic [DW-1:0] s = '0;
    for (int i = 0; i < KK; i++) s += accel_multiplier[i*DW +: DW] * accel_multiplicand[i*DW +: DW];
    return s;
  endfunction

  function automatic logic [OPW-1:0] packWin(input int ch);
    logic [OPW-1:0] p;
    for (int i = 0; i < KK; i++) p[i*DW +: DW] = winMem[ch][i];
    return p;
  endfunction

  function automatic logic [OPW-1:0] packFilt(input int ch);
    logic [OPW-1:0] p;
    for (int i = 0; i < KK; i++) p[i*DW +: DW] = filtMem[ch][i];
    return p;
  endfunction

  function automatic int predictGrant(input logic [CH-1:0] mask);
    for (int k = 0; k < CH; k++)
      if (mask[(modelPtr + k) % CH]) return (modelPtr + k) % CH;
    return 0;
  endfunction

  task automatic randomizeData();
    for (int n = 0; n < CH; n++)
      for (int i = 0; i < KK; i++) begin
        winMem[n][i]  = $urandom;
        filtMem[n][i] = $urandom;
      end
  endtask

  task automatic doReset();
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    modelPtr = 0;
  endtask

  // One full job from an IDLE negedge to the IDLE negedge after the response handshake.
  // latency 0 means the accelerator never answers (timeout build only).
  task automatic applyStimulus(input logic [CH-1:0] mask, input int latency, input int stall,
                               input string name, output int g);
    logic [CH-1:0] oh;
    logic [DW-1:0] expSum;
    logic          expTmo;
    g      = predictGrant(mask);
    oh     = CH'(1) << g;
    expSum = dotProduct(g);
    expTmo = 1'b0;
    bus.req_valid = mask;
    for (int n = 0; n < CH; n++) begin
      bus.req_data[n*OPW +: OPW]   = packWin(n);
      bus.req_filter[n*OPW +: OPW] = packFilt(n);
    end
    bus.rsp_ready = '0;
    #1;
    checkOutput({name, ".req_ready"}, OPW'(bus.req_ready), OPW'(oh));
    @(negedge Clk);
    checkOutput({name, ".start"}, OPW'(accel_start), OPW'({KK{1'b1}}));
    checkOutput({name, ".grant_id"}, OPW'(grant_id), OPW'(g));
    checkOutput({name, ".mult"}, accel_multiplier, packWin(g));
    checkOutput({name, ".mcand"}, accel_multiplicand, packFilt(g));
    checkOutput({name, ".ready_busy"}, OPW'(bus.req_ready), '0);
    if (latency > 0) begin
      for (int c = 1; c <= latency; c++) begin
        @(negedge Clk);
        if (c == 1) checkOutput({name, ".start_once"}, OPW'(accel_start), '0);
        if (c == latency) begin
          accel_ready = 1'b1;
          accel_sum   = accelModelSum();
        end
      end
    end else begin
      for (int c = 1; c <= TMO; c++) begin
        @(negedge Clk);
        if (c == TMO) checkOutput({name, ".no_early_rsp"}, OPW'(bus.rsp_valid), '0);
      end
      expSum = '0;
      expTmo = 1'b1;
    end
    @(negedge Clk);
    accel_ready = 1'b0;
    accel_sum   = $urandom;
    checkOutput({name, ".rsp_valid"}, OPW'(bus.rsp_valid), OPW'(oh));
    checkOutput({name, ".rsp_data"}, OPW'(bus.rsp_data), OPW'(expSum));
    checkOutput({name, ".rsp_timeout"}, OPW'(bus.rsp_timeout), OPW'(expTmo));
    for (int s = 0; s < stall; s++) begin
      bus.rsp_ready = ~oh;
      @(negedge Clk);
      checkOutput({name, ".hold_valid"}, OPW'(bus.rsp_valid), OPW'(oh));
      checkOutput({name, ".hold_data"}, OPW'(bus.rsp_data), OPW'(expSum));
      checkOutput({name, ".hold_noreq"}, OPW'(bus.req_ready), '0);
    end
    bus.rsp_ready = oh;
    @(negedge Clk);
    checkOutput({name, ".busy_done"}, OPW'(busy), '0);
    checkOutput({name, ".rsp_clear"}, OPW'({bus.rsp_valid, bus.rsp_timeout}), '0);
    bus.rsp_ready = '0;
    bus.req_valid = '0;
    modelPtr = (g + 1) % CH;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    modelPtr   = 0;
    Rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_filter = '0;
    bus.rsp_ready = '0;
    accel_ready = 1'b0;
    accel_sum = '0;
    repeat (2) @(negedge Clk);
    checkOutput("reset.busy", OPW'(busy), '0);
    checkOutput("reset.grant_id", OPW'(grant_id), '0);
    checkOutput("reset.rsp", OPW'({bus.rsp_valid, bus.rsp_timeout, bus.rsp_data}), '0);
    checkOutput("reset.start", OPW'(accel_start), '0);
    checkOutput("reset.mult", accel_multiplier, '0);
    Rst = 1'b0;

    // T1: single request, filter selects element 8 -> result 9.
    for (int i = 0; i < KK; i++) begin
      winMem[0][i]  = DW'(i + 1);
      filtMem[0][i] = (i == 8) ? DW'(1) : DW'(0);
    end
    applyStimulus(2'b01, 3, 0, "T1", granted);
    checkOutput("T1.sum9", OPW'(dotProduct(0)), OPW'(9));

    // T2: both channels continuously valid from a fresh pointer -> 0,1,0,1.
    doReset();
    randomizeData();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b11, $urandom_range(1, 4), 0, "T2", granted);
      checkOutput("T2.seq", OPW'(granted), OPW'(k % 2));
    end

    // T3: response backpressure for 5 cycles.
    randomizeData();
    applyStimulus(2'b10, 2, 5, "T3", granted);

    // T4: stale accel_ready while idle must not leak into the next result.
    accel_ready = 1'b1;
    accel_sum   = 32'h0BAD_0BAD;
    @(negedge Clk);
    accel_ready = 1'b0;
    checkOutput("T4.idle", OPW'({busy, bus.rsp_valid}), '0);
    randomizeData();
    applyStimulus(2'b01, 2, 0, "T4", granted);

    // T5: reset while in WAIT abandons the job and returns the pointer to 0.
    bus.req_valid = 2'b10;
    for (int n = 0; n < CH; n++) begin
      bus.req_data[n*OPW +: OPW]   = packWin(n);
      bus.req_filter[n*OPW +: OPW] = packFilt(n);
    end
    @(negedge Clk);
    bus.req_valid = '0;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    modelPtr = 0;
    checkOutput("T5.outs", OPW'({busy, grant_id, bus.rsp_valid, accel_start, bus.rsp_data}), '0);
    checkOutput("T5.mult", accel_multiplier, '0);
    accel_ready = 1'b1;
    accel_sum   = $urandom;
    @(negedge Clk);
    accel_ready = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("T5.no_rsp", OPW'({busy, bus.rsp_valid}), '0);
    applyStimulus(2'b11, 2, 0, "T5", granted);
    checkOutput("T5.ptr0", OPW'(granted), '0);

`ifdef SCHED_TIMEOUT_EN
    // T6: accelerator never answers -> zero result flagged as timed out, then a normal job.
    randomizeData();
    applyStimulus(2'b01, 0, 1, "T6", granted);
    applyStimulus(2'b01, 3, 0, "T6n", granted);
`endif

    // Randomized jobs.
    for (int j = 0; j < 24; j++) begin
      randomizeData();
      applyStimulus(CH'($urandom_range(1, 3)), $urandom_range(1, 6), $urandom_range(0, 3),
                    "rand", granted);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
